// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: picks the next fetch address, raises pipeline flush strobes,
// tracks user/kernel mode, holds EPC and drains the pipe on trap entry.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR   = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        irq,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        kernel,
    output logic        ctrl_flush,
    output logic        branch_flush,
    output logic        exp_flush
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_ENTRY  = 2'd1,
        S_KERNEL = 2'd2
    } state_t;

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_epc, w_epc_nxt;
    logic [31:0] w_pc_plus4;
    logic        w_ctrl_flush, w_branch_flush, w_exp_flush;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
            r_cnt   <= 3'd0;
            r_pc    <= RESET_PC;
            r_epc   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pc    <= w_pc_nxt;
            r_epc   <= w_epc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pc_nxt       = r_pc;
        w_epc_nxt      = r_epc;
        w_ctrl_flush   = 1'b0;
        w_branch_flush = 1'b0;
        w_exp_flush    = 1'b0;
        case (r_state)
            S_ENTRY: begin
                // Drain: every input except reset is ignored until the count runs out.
                w_exp_flush = 1'b1;
                if (r_cnt == 3'd0) w_state_nxt = S_KERNEL;
                else               w_cnt_nxt   = r_cnt - 3'd1;
            end
            default: begin
                if (exc_req) begin
                    w_pc_nxt    = EXC_VECTOR;
                    w_epc_nxt   = exc_pc;
                    w_exp_flush = 1'b1;
                    w_state_nxt = S_ENTRY;
                    w_cnt_nxt   = DRAIN_LOAD;
                end else if (irq && r_state == S_RUN) begin
                    // Return to whatever would have been fetched next.
                    w_pc_nxt    = INT_VECTOR;
                    w_epc_nxt   = branch_taken ? branch_target :
                                  jump         ? jump_target   : r_pc;
                    w_exp_flush = 1'b1;
                    w_state_nxt = S_ENTRY;
                    w_cnt_nxt   = DRAIN_LOAD;
                end else if (eret && r_state == S_KERNEL) begin
                    w_pc_nxt     = r_epc;
                    w_ctrl_flush = 1'b1;
                    w_state_nxt  = S_RUN;
                end else if (branch_taken) begin
                    w_pc_nxt       = branch_target;
                    w_branch_flush = 1'b1;
                end else if (jump) begin
                    w_pc_nxt     = jump_target;
                    w_ctrl_flush = 1'b1;
                end else if (!stall) begin
                    w_pc_nxt = w_pc_plus4;
                end
            end
        endcase
    end

    // Flushes are suppressed while reset is held, since inputs may still toggle.
    assign ctrl_flush   = w_ctrl_flush   & reset;
    assign branch_flush = w_branch_flush & reset;
    assign exp_flush    = w_exp_flush    & reset;
    assign pc           = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign epc          = r_epc;
    assign kernel       = (r_state != S_RUN);

endmodule
